// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: address-field
// widths for the default geometry, width helpers and the refill FSM states.
package instr_cache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OFFSET_W = 2;

    function automatic int unsigned index_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned word_w(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
        return ADDR_W - index_w(lines) - word_w(words) - OFFSET_W;
    endfunction

    // Default split: offset [1:0], word [3:2], index [7:4], tag [31:8]
    localparam int unsigned WORD_W  = word_w(4);
    localparam int unsigned INDEX_W = index_w(16);
    localparam int unsigned TAG_W   = tag_w(16, 4);

    typedef enum logic [1:0] {
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT
    } state_e;

endpackage

// File: rtl/instr_cache_array.sv
// Valid/tag/data storage: asynchronous read of one word plus its line's tag
// and valid bit, synchronous word write and a set-valid/tag strobe.
module instr_cache_array
    import instr_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = 1 << INDEX_W,
    parameter int unsigned WORDS_PER_LINE = 1 << WORD_W,
    parameter int unsigned TAG_BITS       = TAG_W,
    localparam int unsigned IDX_W         = index_w(NUM_LINES),
    localparam int unsigned WRD_W         = word_w(WORDS_PER_LINE)
) (
    input  logic                clk,
    input  logic                res,
    input  logic [IDX_W-1:0]    rd_index,
    input  logic [WRD_W-1:0]    rd_word,
    output logic [DATA_W-1:0]   rd_data,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_valid,
    input  logic                we,
    input  logic [IDX_W-1:0]    w_index,
    input  logic [WRD_W-1:0]    w_word,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                set_valid,
    input  logic [TAG_BITS-1:0] w_tag
);

    logic [DATA_W-1:0]   data_q [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_BITS-1:0] tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[w_index] <= 1'b1;
        end
    end

    // Data and tags need no reset: a line is only readable once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[w_index][w_word] <= w_data;
        end
        if (set_valid) begin
            tag_q[w_index] <= w_tag;
        end
    end

    assign rd_data  = data_q[rd_index][rd_word];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, whole-line refill
// one word at a time over the same req/gnt/rvalid handshake.
module instruction_cache
    import instr_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = 1 << INDEX_W,
    parameter int unsigned WORDS_PER_LINE = 1 << WORD_W,
    localparam int unsigned IDX_W         = index_w(NUM_LINES),
    localparam int unsigned WRD_W         = word_w(WORDS_PER_LINE),
    localparam int unsigned TAG_BITS      = tag_w(NUM_LINES, WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cached_instr_req,
    input  logic [ADDR_W-1:0] cached_instr_adr,
    output logic              cached_instr_gnt,
    output logic              cached_instr_rvalid,
    output logic [DATA_W-1:0] cached_instr_read,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_adr,
    input  logic              instr_gnt,
    input  logic              instr_rvalid,
    input  logic [DATA_W-1:0] instr_read
);

    state_e               state_q, state_d;
    logic [WRD_W-1:0]     cnt_q, cnt_d;
    logic [TAG_BITS-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    read_q, read_d;

    logic [TAG_BITS-1:0]  a_tag;
    logic [IDX_W-1:0]     a_idx;
    logic [WRD_W-1:0]     a_word;
    logic                 unused_offset;
    logic [DATA_W-1:0]    rd_data;
    logic [TAG_BITS-1:0]  rd_tag;
    logic                 rd_valid;
    logic                 hit;
    logic                 we;
    logic                 set_valid;

    assign a_tag         = cached_instr_adr[ADDR_W-1 -: TAG_BITS];
    assign a_idx         = cached_instr_adr[OFFSET_W+WRD_W +: IDX_W];
    assign a_word        = cached_instr_adr[OFFSET_W +: WRD_W];
    assign unused_offset = ^cached_instr_adr[OFFSET_W-1:0];
    assign hit           = rd_valid && (rd_tag == a_tag);

    instr_cache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clk       (clk),
        .res       (res),
        .rd_index  (a_idx),
        .rd_word   (a_word),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .we        (we),
        .w_index   (idx_q),
        .w_word    (cnt_q),
        .w_data    (instr_read),
        .set_valid (set_valid),
        .w_tag     (tag_q)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= LOOKUP;
            cnt_q    <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            read_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
            read_q   <= read_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        tag_d            = tag_q;
        idx_d            = idx_q;
        rvalid_d         = 1'b0;
        read_d           = read_q;
        cached_instr_gnt = 1'b0;
        instr_req        = 1'b0;
        we               = 1'b0;
        set_valid        = 1'b0;
        case (state_q)
            LOOKUP: begin
                if (cached_instr_req) begin
                    if (hit) begin
                        cached_instr_gnt = 1'b1;
                        rvalid_d         = 1'b1;
                        read_d           = rd_data;
                    end else begin
                        tag_d   = a_tag;
                        idx_d   = a_idx;
                        cnt_d   = '0;
                        state_d = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                instr_req = 1'b1;
                if (instr_gnt) begin
                    state_d = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (instr_rvalid) begin
                    we = 1'b1;
                    if (cnt_q == WRD_W'(WORDS_PER_LINE - 1)) begin
                        set_valid = 1'b1;
                        state_d   = LOOKUP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = REFILL_REQ;
                    end
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    // Held line base plus word counter keeps the address stable across gnt stalls.
    assign instr_adr           = {tag_q, idx_q, cnt_q, {OFFSET_W{1'b0}}};
    assign cached_instr_rvalid = rvalid_q;
    assign cached_instr_read   = read_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a configurable-latency memory model.
module tb_instruction_cache;

    logic        clk;
    logic        res;
    logic        cached_instr_req;
    logic [31:0] cached_instr_adr;
    logic        cached_instr_gnt;
    logic        cached_instr_rvalid;
    logic [31:0] cached_instr_read;
    logic        instr_req;
    logic [31:0] instr_adr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_read;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          spur_cnt  = 0;
    logic [31:0] mem_log [$];

    instruction_cache #(
        .NUM_LINES      (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk                 (clk),
        .res                 (res),
        .cached_instr_req    (cached_instr_req),
        .cached_instr_adr    (cached_instr_adr),
        .cached_instr_gnt    (cached_instr_gnt),
        .cached_instr_rvalid (cached_instr_rvalid),
        .cached_instr_read   (cached_instr_read),
        .instr_req           (instr_req),
        .instr_adr           (instr_adr),
        .instr_gnt           (instr_gnt),
        .instr_rvalid        (instr_rvalid),
        .instr_read          (instr_read)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: grants after gnt_delay waiting cycles, returns data rv_delay cycles after the grant cycle.
    initial begin
        int          wait_cnt;
        int          rv_cnt;
        int          spur_done;
        logic        rv_pending;
        logic [31:0] rv_addr;
        logic [31:0] held_adr;
        wait_cnt = 0; rv_cnt = 0; spur_done = 0; rv_pending = 1'b0;
        rv_addr = '0; held_adr = '0;
        instr_gnt = 1'b0; instr_rvalid = 1'b0; instr_read = '0;
        forever begin
            @(posedge clk);
            #1;
            instr_gnt    = 1'b0;
            instr_rvalid = 1'b0;
            if (rv_pending) begin
                if (rv_cnt == 0) begin
                    instr_rvalid = 1'b1;
                    instr_read   = memval(rv_addr);
                    rv_pending   = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (spur_cnt != spur_done) begin
                instr_rvalid = 1'b1;
                instr_read   = 32'hDEADBEEF;
                spur_done++;
            end
            if (wait_cnt > 0) begin
                chk("mem req held", {31'b0, instr_req}, 32'd1);
                chk("mem adr stable", instr_adr, held_adr);
            end
            if (instr_req) begin
                if (wait_cnt == 0) held_adr = instr_adr;
                if (wait_cnt >= gnt_delay) begin
                    instr_gnt  = 1'b1;
                    mem_log.push_back(instr_adr);
                    rv_pending = 1'b1;
                    rv_cnt     = rv_delay;
                    rv_addr    = instr_adr;
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int exp_lat, input string tag);
        int cyc;
        cyc = 0;
        @(negedge clk);
        cached_instr_req = 1'b1;
        cached_instr_adr = a;
        #1;
        while (!cached_instr_gnt && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({tag, " gnt"}, {31'b0, cached_instr_gnt}, 32'd1);
        chk({tag, " latency"}, cyc, exp_lat);
        @(negedge clk);
        cached_instr_req = 1'b0;
        #1;
        chk({tag, " rvalid"}, {31'b0, cached_instr_rvalid}, 32'd1);
        chk({tag, " data"}, cached_instr_read, memval({a[31:2], 2'b00}));
        @(negedge clk);
        #1;
        chk({tag, " rvalid one cycle"}, {31'b0, cached_instr_rvalid}, 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        res = 1'b1;
        cached_instr_req = 1'b0;
        cached_instr_adr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset gnt", {31'b0, cached_instr_gnt}, 32'd0);
        chk("reset rvalid", {31'b0, cached_instr_rvalid}, 32'd0);
        chk("reset read", cached_instr_read, 32'd0);
        chk("reset instr_req", {31'b0, instr_req}, 32'd0);
        chk("reset instr_adr", instr_adr, 32'd0);
        @(negedge clk);
        res = 1'b0;

        // Cold miss on 0x0: four word requests in order, gnt at cycle 9
        mem_log.delete();
        fetch(32'h0, 9, "cold miss 0x0");
        chk("cold miss req count", mem_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < mem_log.size()) chk("cold miss req adr", mem_log[i], 32'(i * 4));
        end

        n = mem_log.size();
        fetch(32'h4, 0, "hit 0x4");
        fetch(32'h8, 0, "hit 0x8");
        fetch(32'hE, 0, "hit 0xC (offset ignored)");

        // Back-to-back hit stream, one word per cycle
        @(negedge clk);
        cached_instr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cached_instr_adr = 32'(i * 4);
            #1;
            chk("stream gnt", {31'b0, cached_instr_gnt}, 32'd1);
            if (i > 0) begin
                chk("stream rvalid", {31'b0, cached_instr_rvalid}, 32'd1);
                chk("stream data", cached_instr_read, memval(32'((i - 1) * 4)));
            end
            @(negedge clk);
        end
        cached_instr_req = 1'b0;
        #1;
        chk("stream last rvalid", {31'b0, cached_instr_rvalid}, 32'd1);
        chk("stream last data", cached_instr_read, memval(32'hC));
        chk("hits no mem req", mem_log.size(), n);

        // Conflict on index 0
        mem_log.delete();
        fetch(32'h100, 9, "conflict 0x100");
        chk("conflict 0x100 req count", mem_log.size(), 32'd4);
        if (mem_log.size() > 0) chk("conflict 0x100 first adr", mem_log[0], 32'h100);
        fetch(32'h0, 9, "conflict back 0x0");
        chk("conflict back req count", mem_log.size(), 32'd8);

        // Spurious rvalid in LOOKUP must not write or respond
        spur_cnt++;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("spurious no rvalid", {31'b0, cached_instr_rvalid}, 32'd0);
        end
        fetch(32'h0, 0, "after spurious 0x0");
        fetch(32'hC, 0, "after spurious 0xC");

        // Slow memory: per word 4 cycles in REFILL_REQ, 3 in REFILL_WAIT
        gnt_delay = 3;
        rv_delay  = 2;
        mem_log.delete();
        fetch(32'h344, 29, "slow mem 0x344");
        chk("slow mem req count", mem_log.size(), 32'd4);
        if (mem_log.size() > 3) chk("slow mem last adr", mem_log[3], 32'h34C);
        gnt_delay = 0;
        fetch(32'h340, 0, "slow mem hit 0x340");

        // Reset after word 0 returned and word 1 granted
        rv_delay = 2;
        mem_log.delete();
        @(negedge clk);
        cached_instr_req = 1'b1;
        cached_instr_adr = 32'h200;
        cyc = 0;
        #1;
        while (mem_log.size() < 2 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("abort reached word 1", mem_log.size(), 32'd2);
        res = 1'b1;
        #1;
        chk("abort reset instr_req", {31'b0, instr_req}, 32'd0);
        chk("abort reset gnt", {31'b0, cached_instr_gnt}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        cached_instr_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("abort stale no rvalid", {31'b0, cached_instr_rvalid}, 32'd0);
        end
        rv_delay = 0;
        mem_log.delete();
        fetch(32'h200, 9, "refetch 0x200");
        chk("refetch req count", mem_log.size(), 32'd4);
        if (mem_log.size() > 0) chk("refetch first adr", mem_log[0], 32'h200);
        fetch(32'h204, 0, "refetch hit 0x204");
        fetch(32'h0, 9, "line 0 invalid after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the processor's instruction fetch port and the instruction memory port of the SoC. Both sides use the same req/gnt/rvalid handshake. Hits are served with a one-cycle turnaround. Misses fetch a whole line from memory, one word at a time, then serve the request from the cache.

## Interface
Parameters:
- `NUM_LINES`, default 16: number of lines; must be a power of 2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; must be a power of 2.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all logic is rising-edge.
- `res`  in  1  asynchronous, active-high reset.

Processor side:
- `cached_instr_req`  in  1  fetch request.
- `cached_instr_adr`  in  32  fetch byte address; bits [1:0] are ignored.
- `cached_instr_gnt`  out  1  request accepted.
- `cached_instr_rvalid`  out  1  `cached_instr_read` is valid.
- `cached_instr_read`  out  32  fetched instruction.

Memory side:
- `instr_req`  out  1  word read request.
- `instr_adr`  out  32  word-aligned byte address.
- `instr_gnt`  in  1  memory accepted the request.
- `instr_rvalid`  in  1  memory data is valid.
- `instr_read`  in  32  memory data.

## Operation
- Address split, with the default parameters:
  - offset = [1:0]
  - word = [3:2]
  - index = [7:4]
  - tag = [31:8]
- Field widths are derived as $clog2 of the parameters.
- Storage per line: valid bit, tag, and `WORDS_PER_LINE` data words.
- Hit: `valid[index] && tag[index] == adr tag`.
- FSM states:
  - LOOKUP:
    - If req and hit: `cached_instr_gnt`=1 combinationally in the same cycle.
    - The word is registered into `cached_instr_read`, and `cached_instr_rvalid`=1 for exactly the next cycle.
    - If req and miss: `gnt`=0, latch the line base address, set the word counter to 0, go to REFILL_REQ.
  - REFILL_REQ:
    - Drive `instr_req`=1 and `instr_adr`={tag, index, cnt, 2'b00}.
    - These stay stable until `instr_gnt`; on `instr_gnt`, go to REFILL_WAIT.
  - REFILL_WAIT:
    - `instr_req`=0; wait for `instr_rvalid`.
    - On `instr_rvalid`: write `instr_read` into word cnt of the line.
    - If cnt==WORDS_PER_LINE-1: set valid and tag, go to LOOKUP. Otherwise increment cnt and go to REFILL_REQ.
- After a refill, LOOKUP re-evaluates the still-held request, which now hits.
- The processor holds req and address stable until gnt. The cache never grants during a refill.
- At most one memory request is outstanding at a time.
- `instr_rvalid` outside REFILL_WAIT is ignored.
- The valid bit is set only after the last word arrives; a line is never partially valid.
- A refill replaces the whole indexed line, since the cache is direct-mapped.
- `cached_instr_read` holds its last value between rvalid pulses.
- There is no write path and no flush input. Reset is the only invalidation.

## Timing
- Reset values:
  - All outputs 0; `cached_instr_read`=0 and `instr_adr`=0.
  - All valid bits cleared; state LOOKUP; cnt=0.
- Reset during a refill abandons it. The line stays invalid, and any later `instr_rvalid` for it is ignored.
- Hit latency: gnt in cycle 0, rvalid and data in cycle 1.
- Back-to-back hits can be granted every cycle.
- Miss latency with a zero-wait memory (gnt same cycle as req, rvalid one cycle later):
  - Refill takes 2·WORDS_PER_LINE cycles.
  - gnt arrives 2·WORDS_PER_LINE+1 cycles after the first req; with the defaults, gnt at cycle 9 and rvalid at cycle 10.
- Memory stalls on gnt or rvalid lengthen the refill cycle for cycle.

## Structure
- Shared package `instr_cache_pkg`:
  - address-field width localparams (offset, word, index, tag);
  - FSM state enum {LOOKUP, REFILL_REQ, REFILL_WAIT}.
- One natural sub-module, `instr_cache_array`:
  - holds the valid, tag and data storage;
  - one asynchronous read port (index, word) returning data, tag and valid;
  - one synchronous word-write port plus a set-valid/tag strobe;
  - async-clears the valid bits on `res`.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- Reset, then immediately req to 0x00000000 → no gnt; memory sees requests to 0x0, 0x4, 0x8, 0xC in order. Then gnt at cycle 9 and rvalid at cycle 10, returning mem[0x0].
- Requests to 0x4, 0x8, 0xC after that refill → each is granted in the same cycle with rvalid the next cycle, with zero memory requests. A back-to-back stream gives one word per cycle.
- Conflict: fetch 0x000, then 0x100 (same index, different tag), then 0x000 → each causes a full refill and the correct data is returned each time.
- Memory gnt delayed 3 cycles and rvalid delayed 2 → `instr_req` and `instr_adr` are stable throughout, the refill lengthens accordingly, and the data is correct.
- Assert `res` midway through a refill (after word 1), then re-request the same address → a fresh 4-word refill starts from word 0, and the stale `instr_rvalid` is ignored.
- Spurious `instr_rvalid` while in LOOKUP → no array write and no `cached_instr_rvalid`.
